// File: rtl/key_schedule_seq.sv
// ---------------------------------------------------------------------------
// key_schedule_seq
//
// Sequential AES-128 key expansion. A 128-bit cipher key is latched on
// i_start, then the 11 round keys (index 0..10) are offered one at a time on
// a valid/ready stream. Each accepted key (except the last) is replaced in
// the same register by the next round key, so a steady i_ready gives one key
// per clock. Acceptance of round key 10 ends the run with a one-cycle o_done.
//
// Ports:
//   i_clk        clock, rising edge
//   i_rst_n      asynchronous active-low reset
//   i_start      single-cycle request to start expansion of i_key (IDLE only)
//   i_key        cipher key, word0 = [127:96] ... word3 = [31:0]
//   i_ready      downstream accepts o_round_key this cycle
//   o_round_key  current round key, same word order as i_key
//   o_round_idx  index of o_round_key, 0..10
//   o_valid      o_round_key / o_round_idx are valid
//   o_busy       expansion in progress
//   o_done       one-cycle pulse after round key 10 is accepted
// ---------------------------------------------------------------------------
module key_schedule_seq #(
    parameter int NR = 10
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_start,
    input  logic [127:0] i_key,
    input  logic         i_ready,
    output logic [127:0] o_round_key,
    output logic [3:0]   o_round_idx,
    output logic         o_valid,
    output logic         o_busy,
    output logic         o_done
);

    localparam logic [3:0] LastIdx = 4'(NR);

    // AES S-box, entry 0 in the most significant byte.
    localparam logic [2047:0] SboxTable = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        sbox = SboxTable[(255 - int'(b)) * 8 +: 8];
    endfunction

    // Round constant used when advancing from round key idx to idx+1.
    // idx 10 is never advanced, so it falls into the default.
    function automatic logic [7:0] rconNext(input logic [3:0] idx);
        case (idx)
            4'd0:    rconNext = 8'h01;
            4'd1:    rconNext = 8'h02;
            4'd2:    rconNext = 8'h04;
            4'd3:    rconNext = 8'h08;
            4'd4:    rconNext = 8'h10;
            4'd5:    rconNext = 8'h20;
            4'd6:    rconNext = 8'h40;
            4'd7:    rconNext = 8'h80;
            4'd8:    rconNext = 8'h1b;
            4'd9:    rconNext = 8'h36;
            default: rconNext = 8'h00;
        endcase
    endfunction

    typedef enum logic {
        IDLE,
        RUN
    } state_e;

    state_e       state_q, state_d;
    logic [127:0] key_q, key_d;
    logic [3:0]   idx_q, idx_d;
    logic         valid_q, valid_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;

    logic         handshake;
    logic         lastKey;

    logic [31:0]  w0, w1, w2, w3;
    logic [31:0]  rotW, subW, tWord;
    logic [31:0]  n0, n1, n2, n3;
    logic [127:0] nextKey;

    assign handshake = valid_q & i_ready;
    assign lastKey   = (idx_q == LastIdx);

    // Next round key from the current one: the last word is rotated,
    // substituted and mixed with the round constant, then chained through
    // all four words.
    assign {w0, w1, w2, w3} = key_q;
    assign rotW    = {w3[23:0], w3[31:24]};
    assign subW    = {sbox(rotW[31:24]), sbox(rotW[23:16]), sbox(rotW[15:8]), sbox(rotW[7:0])};
    assign tWord   = subW ^ {rconNext(idx_q), 24'h000000};
    assign n0      = w0 ^ tWord;
    assign n1      = w1 ^ n0;
    assign n2      = w2 ^ n1;
    assign n3      = w3 ^ n2;
    assign nextKey = {n0, n1, n2, n3};

    // State and output registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            key_q   <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (i_start) state_d = RUN;
            RUN:  if (handshake && lastKey) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next values of the registered outputs. Everything holds unless a
    // start is accepted or a key is handed off; o_done lasts one cycle.
    always_comb begin
        key_d   = key_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_start) begin
                    key_d   = i_key;
                    idx_d   = '0;
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            RUN: begin
                if (handshake) begin
                    if (lastKey) begin
                        valid_d = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        key_d = nextKey;
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            default: begin
                valid_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign o_round_key = key_q;
    assign o_round_idx = idx_q;
    assign o_valid     = valid_q;
    assign o_busy      = busy_q;
    assign o_done      = done_q;

endmodule

// File: tb/tb_key_schedule_seq.sv
// ---------------------------------------------------------------------------
// tb_key_schedule_seq
//
// Self-checking bench for key_schedule_seq. Expected round keys (FIPS-197
// Appendix A.1 schedule and the all-zero key) are pushed to a scoreboard
// queue when i_start is driven and popped whenever a handshake is observed.
// Inputs are driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_key_schedule_seq;

    typedef struct {
        logic [3:0]   idx;
        logic [127:0] key;
        bit           known;
    } exp_t;

    localparam logic [127:0] FipsKey = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    logic         clock;
    logic         rstN;
    logic         start;
    logic [127:0] key;
    logic         ready;
    logic [127:0] roundKey;
    logic [3:0]   roundIdx;
    logic         valid;
    logic         busy;
    logic         done;

    int           errors;
    int           checks;
    exp_t         sbq[$];
    logic [127:0] fipsKeys[11];

    key_schedule_seq #(.NR(10)) dut (
        .i_clk       (clock),
        .i_rst_n     (rstN),
        .i_start     (start),
        .i_key       (key),
        .i_ready     (ready),
        .o_round_key (roundKey),
        .o_round_idx (roundIdx),
        .o_valid     (valid),
        .o_busy      (busy),
        .o_done      (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic pushFips();
        for (int i = 0; i < 11; i++) sbq.push_back(exp_t'{4'(i), fipsKeys[i], 1'b1});
    endtask

    task automatic pushZero();
        for (int i = 0; i < 11; i++) sbq.push_back(exp_t'{4'(i), 128'h0, 1'b0});
        sbq[0].known = 1'b1;
        sbq[sbq.size() - 10].key   = 128'h62636363626363636263636362636363;
        sbq[sbq.size() - 10].known = 1'b1;
        sbq[sbq.size() - 1].key    = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
        sbq[sbq.size() - 1].known  = 1'b1;
    endtask

    task automatic test_reset();
        rstN  = 1'b0;
        start = 1'b0;
        ready = 1'b0;
        key   = '0;
        repeat (2) @(negedge clock);
        checks++;
        if ({roundKey, roundIdx, valid, busy, done} !== 135'h0) begin
            errors++;
            $display("[TB] FAIL reset_state: key=%h idx=%0d valid=%b busy=%b done=%b, required all zero",
                     roundKey, roundIdx, valid, busy, done);
        end
        rstN = 1'b1;
        @(negedge clock);
        checks++;
        if (valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_idle: valid=%b busy=%b done=%b, required 0 0 0", valid, busy, done);
        end
    endtask

    task automatic test_fips_full_rate();
        bit   finished = 0;
        int   doneCycle = -1;
        exp_t e;
        @(negedge clock);
        key   = FipsKey;
        start = 1'b1;
        ready = 1'b1;
        pushFips();
        for (int cyc = 0; cyc < 40 && !finished; cyc++) begin
            @(negedge clock);
            start = 1'b0;
            key   = {$urandom, $urandom, $urandom, $urandom};
            if (cyc == 0) begin
                checks++;
                if (busy !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL full_busy: busy=%b, required 1", busy);
                end
            end
            if (valid === 1'b1) begin
                checks++;
                if (sbq.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL full_extra_key: idx=%0d key=%h, required no key", roundIdx, roundKey);
                end else begin
                    e = sbq.pop_front();
                    if (roundIdx !== e.idx || roundKey !== e.key) begin
                        errors++;
                        $display("[TB] FAIL full_key: idx=%0d key=%h, required idx=%0d key=%h",
                                 roundIdx, roundKey, e.idx, e.key);
                    end
                end
            end
            if (done === 1'b1) begin
                finished  = 1;
                doneCycle = cyc;
            end
        end
        checks++;
        if (doneCycle != 11) begin
            errors++;
            $display("[TB] FAIL full_done_latency: done at sample %0d, required 11", doneCycle);
        end
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("[TB] FAIL full_missing: %0d keys not seen, required 0", sbq.size());
        end
        @(negedge clock);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL full_done_pulse: done=%b busy=%b valid=%b, required 0 0 0", done, busy, valid);
        end
        sbq.delete();
    endtask

    task automatic test_stall_random();
        bit           finished = 0;
        bit           stalled = 0;
        int           stallLeft = 5;
        logic [127:0] prevKey = '0;
        logic [3:0]   prevIdx = '0;
        exp_t         e;
        @(negedge clock);
        key   = FipsKey;
        start = 1'b1;
        ready = 1'b0;
        pushFips();
        for (int cyc = 0; cyc < 600 && !finished; cyc++) begin
            @(negedge clock);
            start = 1'b0;
            key   = {$urandom, $urandom, $urandom, $urandom};
            if (stalled && valid === 1'b1) begin
                checks++;
                if (roundKey !== prevKey || roundIdx !== prevIdx) begin
                    errors++;
                    $display("[TB] FAIL stall_hold: idx=%0d key=%h, required idx=%0d key=%h",
                             roundIdx, roundKey, prevIdx, prevKey);
                end
            end
            if (stallLeft > 0) begin
                ready = 1'b0;
                stallLeft--;
            end else if ($urandom_range(0, 5) == 0) begin
                ready     = 1'b0;
                stallLeft = 4;
            end else begin
                ready = 1'($urandom_range(0, 1));
            end
            if (valid === 1'b1 && ready) begin
                checks++;
                if (sbq.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL stall_extra_key: idx=%0d, required no key", roundIdx);
                end else begin
                    e = sbq.pop_front();
                    if (roundIdx !== e.idx || roundKey !== e.key) begin
                        errors++;
                        $display("[TB] FAIL stall_key: idx=%0d key=%h, required idx=%0d key=%h",
                                 roundIdx, roundKey, e.idx, e.key);
                    end
                end
            end
            stalled = (valid === 1'b1) && !ready;
            prevKey = roundKey;
            prevIdx = roundIdx;
            if (done === 1'b1) finished = 1;
        end
        checks++;
        if (!finished || sbq.size() != 0) begin
            errors++;
            $display("[TB] FAIL stall_complete: done_seen=%0d keys_left=%0d, required 1 and 0", finished, sbq.size());
        end
        ready = 1'b1;
        sbq.delete();
    endtask

    task automatic test_zero_key();
        bit   finished = 0;
        exp_t e;
        @(negedge clock);
        key   = '0;
        start = 1'b1;
        ready = 1'b1;
        pushZero();
        for (int cyc = 0; cyc < 40 && !finished; cyc++) begin
            @(negedge clock);
            start = 1'b0;
            if (valid === 1'b1 && sbq.size() != 0) begin
                e = sbq.pop_front();
                checks++;
                if (roundIdx !== e.idx || (e.known && roundKey !== e.key)) begin
                    errors++;
                    $display("[TB] FAIL zero_key: idx=%0d key=%h, required idx=%0d key=%h",
                             roundIdx, roundKey, e.idx, e.key);
                end
            end
            if (done === 1'b1) finished = 1;
        end
        checks++;
        if (!finished || sbq.size() != 0) begin
            errors++;
            $display("[TB] FAIL zero_complete: done_seen=%0d keys_left=%0d, required 1 and 0", finished, sbq.size());
        end
        sbq.delete();
    endtask

    task automatic test_start_during_run_and_done();
        int   doneCount = 0;
        bit   injected = 0;
        exp_t e;
        @(negedge clock);
        key   = FipsKey;
        start = 1'b1;
        ready = 1'b1;
        pushFips();
        for (int cyc = 0; cyc < 60 && doneCount < 2; cyc++) begin
            @(negedge clock);
            start = 1'b0;
            if (valid === 1'b1) begin
                checks++;
                if (sbq.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL restart_extra_key: idx=%0d, required no key", roundIdx);
                end else begin
                    e = sbq.pop_front();
                    if (roundIdx !== e.idx || (e.known && roundKey !== e.key)) begin
                        errors++;
                        $display("[TB] FAIL restart_key: idx=%0d key=%h, required idx=%0d key=%h",
                                 roundIdx, roundKey, e.idx, e.key);
                    end
                end
                if (roundIdx === 4'd4 && !injected) begin
                    injected = 1;
                    start    = 1'b1;
                    key      = 128'hffeeddccbbaa99887766554433221100;
                end
            end
            if (done === 1'b1) begin
                doneCount++;
                if (doneCount == 1) begin
                    start = 1'b1;
                    key   = '0;
                    pushZero();
                end
            end
        end
        checks++;
        if (doneCount != 2 || sbq.size() != 0) begin
            errors++;
            $display("[TB] FAIL restart_complete: done_pulses=%0d keys_left=%0d, required 2 and 0", doneCount, sbq.size());
        end
        start = 1'b0;
        sbq.delete();
    endtask

    task automatic test_reset_mid_run();
        bit   hit = 0;
        bit   finished = 0;
        exp_t e;
        @(negedge clock);
        key   = FipsKey;
        start = 1'b1;
        ready = 1'b1;
        pushFips();
        for (int cyc = 0; cyc < 20 && !hit; cyc++) begin
            @(negedge clock);
            start = 1'b0;
            if (valid === 1'b1 && sbq.size() != 0) begin
                e = sbq.pop_front();
                checks++;
                if (roundIdx !== e.idx || roundKey !== e.key) begin
                    errors++;
                    $display("[TB] FAIL midrst_key: idx=%0d key=%h, required idx=%0d key=%h",
                             roundIdx, roundKey, e.idx, e.key);
                end
                if (e.idx == 4'd3) hit = 1;
            end
        end
        #2 rstN = 1'b0;
        #1;
        checks++;
        if ({roundKey, roundIdx, valid, busy, done} !== 135'h0) begin
            errors++;
            $display("[TB] FAIL midrst_async_clear: key=%h idx=%0d valid=%b busy=%b done=%b, required all zero",
                     roundKey, roundIdx, valid, busy, done);
        end
        sbq.delete();
        repeat (2) @(negedge clock);
        rstN = 1'b1;
        repeat (2) begin
            @(negedge clock);
            checks++;
            if (valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
                errors++;
                $display("[TB] FAIL midrst_idle: valid=%b busy=%b done=%b, required 0 0 0", valid, busy, done);
            end
        end
        key   = FipsKey;
        start = 1'b1;
        pushFips();
        for (int cyc = 0; cyc < 40 && !finished; cyc++) begin
            @(negedge clock);
            start = 1'b0;
            if (valid === 1'b1 && sbq.size() != 0) begin
                e = sbq.pop_front();
                checks++;
                if (roundIdx !== e.idx || roundKey !== e.key) begin
                    errors++;
                    $display("[TB] FAIL midrst_restart_key: idx=%0d key=%h, required idx=%0d key=%h",
                             roundIdx, roundKey, e.idx, e.key);
                end
            end
            if (done === 1'b1) finished = 1;
        end
        checks++;
        if (!finished || sbq.size() != 0) begin
            errors++;
            $display("[TB] FAIL midrst_complete: done_seen=%0d keys_left=%0d, required 1 and 0", finished, sbq.size());
        end
        sbq.delete();
    endtask

    initial begin
        errors = 0;
        checks = 0;
        fipsKeys[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        fipsKeys[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        fipsKeys[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        fipsKeys[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        fipsKeys[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        fipsKeys[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        fipsKeys[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        fipsKeys[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        fipsKeys[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        fipsKeys[9]  = 128'hac7766f319fadc2128d12941575c006e;
        fipsKeys[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

        test_reset();
        test_fips_full_rate();
        test_stall_random();
        test_zero_key();
        test_start_during_run_and_done();
        test_reset_mid_run();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
